// File: rtl/pio_step_scheduler.sv
// Avalon-MM master that polls the 16-pad PIO, debounces presses into a 16-step pattern,
// advances a playhead and writes pattern+playhead to the LEDs. PIO_SCHED_SWING_EN enables swing.
module pio_step_scheduler #(
    parameter int POLL_DIV = 50000,
    parameter int STEP_DIV = 6250000,
    parameter int SWING    = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        clear,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    output logic [15:0] pattern,
    output logic [3:0]  step_idx,
    output logic        trigger
);
    localparam int PCW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    // Sized for the longest swung step so the same counter serves both builds.
    localparam int SCW = $clog2(STEP_DIV + SWING + 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, UPD, WR} state_t;
    state_t state, state_nxt;

    logic [PCW-1:0] poll_cnt;
    logic [SCW-1:0] step_cnt;
    logic [SCW-1:0] step_last;
    logic           poll_pend, step_pend, wr_pend;
    logic           run_q;
    logic [15:0]    s0, s1, stable;
    logic [15:0]    stable_nxt, toggle_bits, disp;
    logic [3:0]     step_next;
    logic           poll_wrap, step_wrap, run_rise, run_fall, do_step;
    logic           unused_readdata;

    assign unused_readdata = &{1'b0, pio_readdata[31:16]};
    assign pio_address     = 2'd0;

`ifdef PIO_SCHED_SWING_EN
    logic step_odd;

    // Parity of the step currently being timed; it leads step_idx by the service latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            step_odd <= 1'b0;
        else if (!run)
            step_odd <= 1'b0;
        else if (step_wrap)
            step_odd <= ~step_odd;
    end

    assign step_last = step_odd ? SCW'(STEP_DIV - SWING - 1) : SCW'(STEP_DIV + SWING - 1);
`else
    assign step_last = SCW'(STEP_DIV - 1);
`endif

    assign poll_wrap   = (poll_cnt == PCW'(POLL_DIV - 1));
    assign step_wrap   = run && (step_cnt == step_last);
    assign run_rise    = run && !run_q;
    assign run_fall    = !run && run_q;
    assign do_step     = (state == IDLE) && !poll_pend && step_pend;
    assign step_next   = step_idx + 4'd1;
    assign stable_nxt  = (s1 == s0) ? s1 : stable;
    assign toggle_bits = stable_nxt & ~stable;
    assign disp        = run ? (pattern ^ (16'h1 << step_idx)) : pattern;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = 32'h0;
        case (state)
            IDLE: begin
                if (poll_pend)
                    state_nxt = RD;
                else if (step_pend || wr_pend)
                    state_nxt = WR;
            end
            RD:  state_nxt = CAP;
            CAP: state_nxt = UPD;
            UPD: state_nxt = IDLE;
            WR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_writedata  = {16'h0, disp};
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Later assignments take priority: sets beat clears, run edges beat stepping, clear beats toggles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt  <= '0;
            step_cnt  <= '0;
            poll_pend <= 1'b0;
            step_pend <= 1'b0;
            wr_pend   <= 1'b0;
            run_q     <= 1'b0;
            s0        <= 16'h0;
            s1        <= 16'h0;
            stable    <= 16'h0;
            pattern   <= 16'h0;
            step_idx  <= 4'd0;
            trigger   <= 1'b0;
        end else begin
            trigger <= 1'b0;
            run_q   <= run;

            if (state == RD)
                poll_pend <= 1'b0;
            if (poll_wrap) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end

            if (state == CAP) begin
                s1 <= pio_readdata[15:0];
                s0 <= s1;
            end

            if (state == WR)
                wr_pend <= 1'b0;
            if (state == UPD) begin
                stable  <= stable_nxt;
                pattern <= pattern ^ toggle_bits;
                if (|toggle_bits)
                    wr_pend <= 1'b1;
            end

            if (do_step) begin
                step_idx  <= step_next;
                trigger   <= pattern[step_next];
                step_pend <= 1'b0;
            end
            if (run) begin
                if (step_wrap) begin
                    step_cnt  <= '0;
                    step_pend <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end

            if (run_rise) begin
                trigger <= pattern[0];
                wr_pend <= 1'b1;
            end
            if (run_fall) begin
                step_idx  <= 4'd0;
                step_cnt  <= '0;
                step_pend <= 1'b0;
                trigger   <= 1'b0;
                wr_pend   <= 1'b1;
            end

            if (clear) begin
                pattern <= 16'h0;
                wr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pio_step_scheduler.sv
// Directed bench for pio_step_scheduler: debounce/toggle vector table plus hand-timed
// sequences for clear-vs-toggle, stepping, poll/step collision and reset mid-write.
`timescale 1ns/1ps
module tb_pio_step_scheduler;
    localparam int POLL_DIV = 8;
    localparam int STEP_DIV = 100;
    localparam int SWING    = 20;
`ifdef PIO_SCHED_SWING_EN
    localparam int EVEN_LEN = STEP_DIV + SWING;
    localparam int ODD_LEN  = STEP_DIV - SWING;
`else
    localparam int EVEN_LEN = STEP_DIV;
    localparam int ODD_LEN  = STEP_DIV;
`endif
    localparam int SLOT = 7;
    localparam int NVEC = 21;

    typedef struct {
        logic [15:0] pad;
        logic [15:0] exp_pattern;
        int          exp_writes;
        logic [15:0] exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, run, clear;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata, pio_readdata;
    logic [15:0] pattern;
    logic [3:0]  step_idx;
    logic        trigger;

    logic [15:0] pad;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [31:0] last_wr = 32'h0;
    logic [31:0] wr_at_step3 = 32'h0;
    logic [3:0]  trig_q[$];
    int          chg_t[$];
    int          wrap_cnt = 0;
    logic [3:0]  prev_idx = 4'd0;
    vec_t        vecs[NVEC];

    pio_step_scheduler #(.POLL_DIV(POLL_DIV), .STEP_DIV(STEP_DIV), .SWING(SWING)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .clear          (clear),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pattern        (pattern),
        .step_idx       (step_idx),
        .trigger        (trigger)
    );

    always #5 clk = ~clk;

    // Registered PIO data register: pad state is visible one clock later.
    always @(posedge clk) pio_readdata <= {16'h0, pad};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (pio_chipselect && !pio_write_n) begin
                wr_count++;
                last_wr = pio_writedata;
                if (step_idx == 4'd3)
                    wr_at_step3 = pio_writedata;
            end
            if (trigger)
                trig_q.push_back(step_idx);
            if (step_idx != prev_idx) begin
                chg_t.push_back(cyc);
                if (prev_idx == 4'd15 && step_idx == 4'd0)
                    wrap_cnt++;
            end
            prev_idx = step_idx;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic wait_slot(input int m);
        do @(negedge clk); while ((cyc % POLL_DIV) != m);
    endtask

    task automatic applyStimulus(input logic [15:0] p);
        pad = p;
        wait_slot(SLOT);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int snap;
        int found;

        vecs[0]  = '{16'h0004, 16'h0000, 0, 16'h0000};
        vecs[1]  = '{16'h0004, 16'h0004, 1, 16'h0004};
        vecs[2]  = '{16'h0004, 16'h0004, 1, 16'h0004};
        vecs[3]  = '{16'h0000, 16'h0004, 1, 16'h0004};
        vecs[4]  = '{16'h0000, 16'h0004, 1, 16'h0004};
        vecs[5]  = '{16'h0004, 16'h0004, 1, 16'h0004};
        vecs[6]  = '{16'h0004, 16'h0000, 2, 16'h0000};
        vecs[7]  = '{16'h0000, 16'h0000, 2, 16'h0000};
        vecs[8]  = '{16'h0001, 16'h0000, 2, 16'h0000};
        vecs[9]  = '{16'h0000, 16'h0000, 2, 16'h0000};
        vecs[10] = '{16'h0001, 16'h0000, 2, 16'h0000};
        vecs[11] = '{16'h0000, 16'h0000, 2, 16'h0000};
        vecs[12] = '{16'h0001, 16'h0000, 2, 16'h0000};
        vecs[13] = '{16'h0000, 16'h0000, 2, 16'h0000};
        vecs[14] = '{16'h0000, 16'h0000, 2, 16'h0000};
        vecs[15] = '{16'h8001, 16'h0000, 2, 16'h0000};
        vecs[16] = '{16'h8001, 16'h8001, 3, 16'h8001};
        vecs[17] = '{16'h8000, 16'h8001, 3, 16'h8001};
        vecs[18] = '{16'h8000, 16'h8001, 3, 16'h8001};
        vecs[19] = '{16'h0000, 16'h8001, 3, 16'h8001};
        vecs[20] = '{16'h0000, 16'h8001, 3, 16'h8001};

        reset_n = 1'b0;
        run     = 1'b0;
        clear   = 1'b0;
        pad     = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pattern", pattern, 32'h0);
        checkOutput("reset_step_idx", step_idx, 32'h0);
        checkOutput("reset_trigger", trigger, 32'h0);
        checkOutput("reset_chipselect", pio_chipselect, 32'h0);
        checkOutput("reset_write_n", pio_write_n, 32'h1);
        checkOutput("reset_writedata", pio_writedata, 32'h0);
        checkOutput("reset_address", pio_address, 32'h0);
        reset_n = 1'b1;
        wait_slot(SLOT);

        $display("[TB] pad debounce/toggle table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pad);
            checkOutput($sformatf("vec%0d_pattern", i), pattern, vecs[i].exp_pattern);
            checkOutput($sformatf("vec%0d_writes", i), wr_count, vecs[i].exp_writes);
            checkOutput($sformatf("vec%0d_lastwr", i), last_wr, {16'h0, vecs[i].exp_last});
        end

        $display("[TB] clear on the UPD cycle of a toggle");
        pad = 16'h0002;
        wait_slot(SLOT);
        wait_slot(3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_slot(SLOT);
        checkOutput("clear_vs_toggle_pattern", pattern, 32'h0);
        checkOutput("clear_vs_toggle_writes", wr_count, 32'd4);
        checkOutput("clear_vs_toggle_lastwr", last_wr, 32'h0);
        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        applyStimulus(16'h0101);
        applyStimulus(16'h0101);
        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        checkOutput("setup_pattern", pattern, 32'h0101);
        checkOutput("setup_writes", wr_count, 32'd5);

        $display("[TB] stepping with pattern 0x0101");
        trig_q.delete();
        chg_t.delete();
        wrap_cnt    = 0;
        wr_at_step3 = 32'hDEAD_BEEF;
        run = 1'b1;
        @(negedge clk);
        checkOutput("rise_trigger", trigger, 32'h1);
        checkOutput("rise_step_idx", step_idx, 32'h0);
        repeat (17 * STEP_DIV + STEP_DIV / 2) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checkOutput("fall_step_idx", step_idx, 32'h0);
        checkOutput("fall_trigger", trigger, 32'h0);
        repeat (10) @(negedge clk);
        checkOutput("fall_write", last_wr, 32'h0101);
        checkOutput("trigger_count", trig_q.size(), 32'd3);
        if (trig_q.size() >= 3) begin
            checkOutput("trigger0_step", trig_q[0], 32'd0);
            checkOutput("trigger1_step", trig_q[1], 32'd8);
            checkOutput("trigger2_step", trig_q[2], 32'd0);
        end
        checkOutput("wrap_15_to_0", wrap_cnt, 32'd1);
        checkOutput("write_at_step3", wr_at_step3, 32'h0109);
        checkRange("step_changes", chg_t.size(), 17, 18);
        if (chg_t.size() >= 3) begin
            checkRange("odd_step_len", chg_t[1] - chg_t[0], ODD_LEN - 5, ODD_LEN + 5);
            checkRange("even_step_len", chg_t[2] - chg_t[1], EVEN_LEN - 5, EVEN_LEN + 5);
        end
        repeat (300) @(negedge clk);
        checkOutput("no_trigger_stopped", trig_q.size(), 32'd3);

        $display("[TB] poll and step wrap in the same cycle with a pad edge");
        wait_slot((POLL_DIV - (EVEN_LEN % POLL_DIV)) % POLL_DIV);
        run = 1'b1;
        p = cyc + 1;
        while (cyc < p + EVEN_LEN - 11) @(negedge clk);
        pad = 16'h0010;
        while (cyc < p + EVEN_LEN - 3) @(negedge clk);
        snap = wr_count;
        while (cyc < p + EVEN_LEN + 12) @(negedge clk);
        checkOutput("collision_writes", wr_count - snap, 32'd1);
        checkOutput("collision_lastwr", last_wr, 32'h0113);
        checkOutput("collision_pattern", pattern, 32'h0111);
        checkOutput("collision_step_idx", step_idx, 32'd1);

        $display("[TB] reset asserted during a write");
        found = 0;
        for (int i = 0; i < 3 * STEP_DIV && found == 0; i++) begin
            @(negedge clk);
            if (pio_chipselect)
                found = 1;
        end
        checkOutput("midwr_found_write", found, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midwr_chipselect", pio_chipselect, 32'h0);
        checkOutput("midwr_write_n", pio_write_n, 32'h1);
        checkOutput("midwr_writedata", pio_writedata, 32'h0);
        checkOutput("midwr_pattern", pattern, 32'h0);
        checkOutput("midwr_step_idx", step_idx, 32'h0);
        run = 1'b0;
        pad = 16'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_pattern", pattern, 32'h0);
        checkOutput("post_reset_step_idx", step_idx, 32'h0);
        checkOutput("post_reset_chipselect", pio_chipselect, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
